// File: rtl/shreg_tx_sequencer.sv
// shreg_tx_sequencer: shares one W-bit shift register among NREQ requesters.
// A round-robin arbiter picks a requester. The FSM then drives the register's
// load/enable/clear controls for one frame: LOAD, W SHIFT cycles, GAP idle cycles.
// Optional build macro SHREG_TX_PAUSE_EN adds i_pause. While i_pause is high in
// SHIFT, it freezes shifting and the shift count.
module shreg_tx_sequencer #(
  parameter  int W    = 4,
  parameter  int NREQ = 2,
  parameter  int GAP  = 1,
  localparam int IDW  = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1,
  localparam int BCW  = $clog2(W) + 1
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*W-1:0] i_data_in,
  input  logic              i_abort,
`ifdef SHREG_TX_PAUSE_EN
  input  logic              i_pause,
`endif
  output logic [NREQ-1:0]   o_gnt,
  output logic [IDW-1:0]    o_owner,
  output logic              o_busy,
  output logic              o_sr_load,
  output logic              o_sr_en,
  output logic              o_sr_sclr,
  output logic [W-1:0]      o_sr_data,
  output logic [BCW-1:0]    o_bit_cnt,
  output logic              o_done
);

  localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_ABORT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_owner;
  logic [IDW-1:0] r_last_owner;
  logic [W-1:0]   r_sr_data;
  logic [BCW-1:0] r_bit_cnt;
  logic [BCW-1:0] w_bit_cnt_nxt;
  logic [GCW-1:0] r_gap_cnt;
  logic [GCW-1:0] w_gap_cnt_nxt;
  logic           w_req_any;
  logic [IDW-1:0] w_winner;
  logic           w_arb_ok;
  logic           w_take;
  logic           w_pause;
  logic           w_last_bit;

`ifdef SHREG_TX_PAUSE_EN
  assign w_pause = i_pause;
`else
  assign w_pause = 1'b0;
`endif

  assign w_last_bit = (r_bit_cnt == BCW'(W - 1));

  // Round-robin pick: first set request after the last owner, wrapping modulo NREQ.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    w_req_any = 1'b0;
    w_winner  = '0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last_owner) + k) % NREQ;
      if (!w_req_any && i_req[idx]) begin
        w_req_any = 1'b1;
        w_winner  = IDW'(idx);
      end
    end
  end

  // Next-state and counter logic. When a frame ends it can hand straight over to
  // the next grant, which keeps the frame cadence at 1+W+GAP cycles.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_arb_ok      = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_arb_ok      = 1'b1;
        w_bit_cnt_nxt = '0;
      end
      S_LOAD: begin
        w_bit_cnt_nxt = '0;
        w_state_nxt   = i_abort ? S_ABORT : S_SHIFT;
      end
      S_SHIFT: begin
        if (i_abort) begin
          w_state_nxt   = S_ABORT;
          w_bit_cnt_nxt = '0;
        end else if (!w_pause) begin
          if (w_last_bit) begin
            if (GAP > 0) begin
              w_state_nxt   = S_GAP;
              w_bit_cnt_nxt = BCW'(W);
              w_gap_cnt_nxt = '0;
            end else begin
              w_state_nxt   = S_IDLE;
              w_bit_cnt_nxt = '0;
              w_arb_ok      = 1'b1;
            end
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GCW'(GAP - 1)) begin
          w_state_nxt   = S_IDLE;
          w_bit_cnt_nxt = '0;
          w_arb_ok      = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt + 1'b1;
        end
      end
      S_ABORT: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt   = S_IDLE;
        w_bit_cnt_nxt = '0;
      end
    endcase
    if (w_arb_ok && w_req_any) begin
      w_take        = 1'b1;
      w_state_nxt   = S_LOAD;
      w_bit_cnt_nxt = '0;
    end
  end

  // State, counters and the grant-time captures of owner and data word.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_owner      <= '0;
      r_last_owner <= IDW'(NREQ - 1);
      r_sr_data    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      if (w_take) begin
        r_owner      <= w_winner;
        r_last_owner <= w_winner;
        r_sr_data    <= i_data_in[int'(w_winner)*W +: W];
      end
    end
  end

  // Output decode from registered state; only i_pause may gate the shift controls.
  always_comb begin
    o_gnt          = '0;
    o_gnt[r_owner] = (r_state == S_LOAD);
  end

  assign o_owner   = r_owner;
  assign o_busy    = (r_state != S_IDLE);
  assign o_sr_load = (r_state == S_LOAD);
  assign o_sr_en   = (r_state == S_LOAD) || ((r_state == S_SHIFT) && !w_pause);
  assign o_sr_sclr = (r_state == S_ABORT);
  assign o_sr_data = r_sr_data;
  assign o_bit_cnt = r_bit_cnt;
  assign o_done    = (r_state == S_SHIFT) && w_last_bit && !w_pause;

endmodule
